// File: rtl/sram_pkg.sv
// ============================================================================
// Module : sram_pkg
// Shared SRAM geometry and word/address types for the k-means point store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_DEPTH  = 4096;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_word_t;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_sp_4096x16.sv
// ============================================================================
// Module : sram_sp_4096x16
// Single-port synchronous SRAM, registered read port, tri-state DO via OE.
// Build option: SRAM_WRITE_THROUGH_EN (output register loads DI on writes).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_sp_4096x16
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output wire  [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              CS,
  input  logic              OE
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] do_q;
  logic [DATA_W-1:0] do_d;

  always_comb begin
    do_d = do_q;
    if (CS) begin
      if (WEB) begin
        do_d = mem[A];
      end else begin
`ifdef SRAM_WRITE_THROUGH_EN
        do_d = DI;
`else
        do_d = do_q;
`endif
      end
    end
  end

  // The array is never reset; rst_n only clears the output register and
  // blocks writes while it is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q <= '0;
    end else begin
      if (CS && !WEB) begin
        mem[A] <= DI;
      end
      do_q <= do_d;
    end
  end

  assign DO = OE ? do_q : {DATA_W{1'bz}};

endmodule : sram_sp_4096x16

`default_nettype wire

// File: tb/tb_sram_sp_4096x16.sv
// ============================================================================
// Module : tb_sram_sp_4096x16
// Directed self-checking bench for sram_sp_4096x16 with a scoreboard queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_sp_4096x16;

  logic        clk;
  logic        rst_n;
  logic [11:0] A;
  logic [15:0] DI;
  wire  [15:0] DO;
  logic        WEB;
  logic        CS;
  logic        OE;

  sram_sp_4096x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .DI    (DI),
    .DO    (DO),
    .WEB   (WEB),
    .CS    (CS),
    .OE    (OE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model [0:4095];
  bit          valid [0:4095];
  logic [15:0] exp_do;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clocked access: compute the expected register value, queue it,
  // clock, then compare what the DUT presents after the edge.
  task automatic cycle(input logic cs, input logic web, input logic [11:0] a,
                       input logic [15:0] di, input string tag);
    logic [15:0] e;
    bit          known;
    CS  = cs;
    WEB = web;
    A   = a;
    DI  = di;
    known = 1'b1;
    if (cs && web) begin
      exp_do = model[a];
      known  = valid[a];
    end else if (cs && !web) begin
`ifdef SRAM_WRITE_THROUGH_EN
      exp_do = di;
`endif
      model[a] = di;
      valid[a] = 1'b1;
    end
    exp_q.push_back(exp_do);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (known) chk(tag, DO, e);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      valid[i] = 1'b0;
      model[i] = '0;
    end
    exp_do = '0;
    A   = '0;
    DI  = '0;
    WEB = 1'b1;
    CS  = 1'b0;
    OE  = 1'b1;
    rst_n = 1'b1;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1 chk("reset_async", DO, 16'h0000);
    @(posedge clk); #1;
    chk("reset_held", DO, 16'h0000);
    #3 rst_n = 1'b1;
    #1 chk("reset_release_no_edge", DO, 16'h0000);
    @(posedge clk); #1;

    // Read of an unwritten word: value undefined, not compared
    cycle(1'b1, 1'b1, 12'd100, 16'h0000, "read_unwritten");

    // Fill and back-to-back readback
    for (int i = 0; i < 4096; i++)
      cycle(1'b1, 1'b0, 12'(i), 16'h1234 ^ 16'(i), "fill_hold");
    for (int k = 0; k < 4096; k++)
      cycle(1'b1, 1'b1, 12'(k), 16'h0000, "readback");

    // Write then read at the top address
    cycle(1'b1, 1'b1, 12'd10,  16'h0000, "pre_write_read");
    cycle(1'b1, 1'b0, 12'hFFF, 16'hABCD, "write_cycle_do");
    cycle(1'b1, 1'b1, 12'hFFF, 16'h0000, "raw_fff");

    // Deselect with a would-be write
    cycle(1'b0, 1'b0, 12'd5, 16'hFFFF, "deselect_hold");
    cycle(1'b0, 1'b1, 12'd6, 16'h0000, "deselect_hold2");
    cycle(1'b1, 1'b1, 12'd5, 16'h0000, "deselect_no_write");

    // Output enable; undriven bits may resolve to 0 in a 2-state simulator
    OE = 1'b0;
    #1;
    n_cmp++;
    assert ((DO === 16'hzzzz) || (DO === 16'h0000))
    else begin
      n_err++;
      $error("FAIL oe_off observed=%h expected=zzzz", DO);
    end
    OE = 1'b1;
    #1 chk("oe_on_restore", DO, 16'h1234 ^ 16'd5);

    // Reset pulse in the middle of a read burst, with a write pending
    for (int k = 20; k < 28; k++)
      cycle(1'b1, 1'b1, 12'(k), 16'h0000, "burst_pre_reset");
    CS  = 1'b1;
    WEB = 1'b0;
    A   = 12'd3;
    DI  = 16'hDEAD;
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_async", DO, 16'h0000);
    @(posedge clk); #1;
    chk("reset_mid_held", DO, 16'h0000);
    #2 rst_n = 1'b1;
    exp_do = 16'h0000;
    cycle(1'b1, 1'b1, 12'd3,  16'h0000, "reset_no_write");
    cycle(1'b1, 1'b1, 12'd0,  16'h0000, "post_reset_0");
    cycle(1'b1, 1'b1, 12'hFFF, 16'h0000, "post_reset_fff");
    cycle(1'b1, 1'b1, 12'd27, 16'h0000, "post_reset_27");

    // Consecutive write/read pairs on the same address
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 12'(k * 513), 16'(k * 16'h1111) ^ 16'h5A5A, "raw_write");
      cycle(1'b1, 1'b1, 12'(k * 513), 16'h0000, "raw_read");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sram_sp_4096x16

`default_nettype wire
